// File: rtl/ifetch_pkg.sv
// Shared types and default constants for the instruction-fetch front end.
package ifetch_pkg;

   localparam int XLEN_DEF   = 32;
   localparam int IWIDTH_DEF = 32;
   localparam int INC_DEF    = 4;
   localparam logic [XLEN_DEF-1:0] RESET_PC_DEF = '0;

   // One buffered fetch: the word together with the PC it was fetched from.
   typedef struct packed {
      logic [XLEN_DEF-1:0]   pc;
      logic [IWIDTH_DEF-1:0] instr;
   } fetch_entry_t;

   function automatic int count_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/ifetch_queue_fifo.sv
// fetch_fifo: DEPTH-entry circular buffer with push/pop/flush and an exposed
// occupancy count; the head entry is read combinationally from storage.
module fetch_fifo
   import ifetch_pkg::*;
#(
   parameter int W     = 64,
   parameter int DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic                          pop,
   input  logic                          flush,
   input  logic [W-1:0]                  wdata,
   output logic [W-1:0]                  rdata,
   output logic [count_width(DEPTH)-1:0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = count_width(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr_reg;
   logic [AW-1:0] wr_ptr_reg;
   logic [CW-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (push && !flush)
         mem[wr_ptr_reg] <= wdata;
   end

   // DEPTH is a power of two, so pointers wrap by plain overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_reg + CW'(push) - CW'(pop);
      end
   end

   assign rdata = mem[rd_ptr_reg];
   assign count = count_reg;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: PC, sequential 1-cycle imem fetch and a fetch
// queue to decode with redirect flush. Optional stall counter: IFETCH_PERF_EN.
module ifetch_queue
   import ifetch_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEF,
   parameter int              IWIDTH   = IWIDTH_DEF,
   parameter int              DEPTH    = 4,
   parameter int              INC      = INC_DEF,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [XLEN-1:0]   imem_addr,
   input  logic [IWIDTH-1:0] imem_rdata,
   input  logic              redirect,
   input  logic [XLEN-1:0]   redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_pc,
   output logic [XLEN-1:0]   out_inc_pc,
   output logic [IWIDTH-1:0] out_instr
`ifdef IFETCH_PERF_EN
   ,
   output logic [31:0]       stall_cnt
`endif
);

   localparam int CW = count_width(DEPTH);
   localparam int OW = CW + 1;
   localparam int W  = XLEN + IWIDTH;

   logic [XLEN-1:0] pc_reg;
   logic [XLEN-1:0] pend_pc_reg;
   logic            pending_reg;
   logic [CW-1:0]   count;
   logic [W-1:0]    head;
   logic [OW-1:0]   occupancy;
   logic            push;
   logic            pop;
   logic            issue;

   assign out_valid = (count != '0);
   assign pop       = out_valid & out_ready & ~redirect;
   assign push      = pending_reg & ~redirect;

   // Credit counts the in-flight fetch and the slot freed by this cycle's pop,
   // which is what lets issue resume in the same cycle as the first pop.
   assign occupancy = OW'(count) + OW'(pending_reg) - OW'(pop);
   assign issue     = ~rst & ~redirect & (occupancy < OW'(DEPTH));

   assign imem_req  = issue;
   assign imem_addr = pc_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_reg      <= RESET_PC;
         pend_pc_reg <= RESET_PC;
         pending_reg <= 1'b0;
      end else if (redirect) begin
         pc_reg      <= redirect_pc;
         pending_reg <= 1'b0;
      end else begin
         pending_reg <= issue;
         if (issue) begin
            pend_pc_reg <= pc_reg;
            pc_reg      <= pc_reg + XLEN'(INC);
         end
      end
   end

   fetch_fifo #(
      .W     (W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (redirect),
      .wdata ({pend_pc_reg, imem_rdata}),
      .rdata (head),
      .count (count)
   );

   assign out_pc     = head[W-1:IWIDTH];
   assign out_instr  = head[IWIDTH-1:0];
   assign out_inc_pc = out_pc + XLEN'(INC);

`ifdef IFETCH_PERF_EN
   logic [1:0]  blank_reg;
   logic [31:0] stall_reg;

   // blank_reg masks the refill bubble of the three cycles after a redirect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blank_reg <= '0;
         stall_reg <= '0;
      end else begin
         if (redirect)
            blank_reg <= 2'd3;
         else if (blank_reg != 2'd0)
            blank_reg <= blank_reg - 2'd1;
         if (!out_valid && blank_reg == 2'd0)
            stall_reg <= stall_reg + 32'd1;
      end
   end

   assign stall_cnt = stall_reg;
`endif

endmodule
